// File: rtl/sram_arb_pkg.sv
// rtl/sram_arb_pkg.sv - shared types and widths for the SRAM port arbiter
package sram_arb_pkg;

    localparam int SRAM_ADDR_W = 18;
    localparam int SRAM_DATA_W = 16;

    typedef enum logic {
        S_FREE       = 1'b0,
        S_DEC_LOCKED = 1'b1
    } arb_state_t;

    typedef enum logic [1:0] {
        TAG_NONE = 2'd0,
        TAG_VGA  = 2'd1,
        TAG_DEC  = 2'd2
    } arb_tag_t;

endpackage

// File: rtl/sram_arbiter_if.sv
// rtl/sram_arbiter_if.sv - requester and SRAM-controller signals of the arbiter
interface sram_arbiter_if;
    import sram_arb_pkg::*;

    logic                   VGA_req;
    logic [SRAM_ADDR_W-1:0] VGA_addr;
    logic                   VGA_gnt;
    logic                   VGA_rvalid;

    logic                   UART_req;
    logic [SRAM_ADDR_W-1:0] UART_addr;
    logic [SRAM_DATA_W-1:0] UART_wdata;
    logic                   UART_gnt;

    logic                   DEC_req;
    logic                   DEC_we_n;
    logic [SRAM_ADDR_W-1:0] DEC_addr;
    logic [SRAM_DATA_W-1:0] DEC_wdata;
    logic                   DEC_lock;
    logic                   DEC_gnt;
    logic                   DEC_rvalid;

    logic [SRAM_ADDR_W-1:0] SRAM_address;
    logic [SRAM_DATA_W-1:0] SRAM_write_data;
    logic                   SRAM_we_n;
    logic [SRAM_DATA_W-1:0] SRAM_read_data;
    logic [SRAM_DATA_W-1:0] SRAM_rdata;

    modport slave (
        input  VGA_req, VGA_addr,
        input  UART_req, UART_addr, UART_wdata,
        input  DEC_req, DEC_we_n, DEC_addr, DEC_wdata, DEC_lock,
        input  SRAM_read_data,
        output VGA_gnt, VGA_rvalid, UART_gnt, DEC_gnt, DEC_rvalid,
        output SRAM_address, SRAM_write_data, SRAM_we_n, SRAM_rdata
    );

    modport master (
        output VGA_req, VGA_addr,
        output UART_req, UART_addr, UART_wdata,
        output DEC_req, DEC_we_n, DEC_addr, DEC_wdata, DEC_lock,
        output SRAM_read_data,
        input  VGA_gnt, VGA_rvalid, UART_gnt, DEC_gnt, DEC_rvalid,
        input  SRAM_address, SRAM_write_data, SRAM_we_n, SRAM_rdata
    );

endinterface

// File: rtl/sram_arb_tag_pipe.sv
// rtl/sram_arb_tag_pipe.sv - read-owner tag delay line aligned to SRAM read latency
module sram_arb_tag_pipe
    import sram_arb_pkg::*;
#(
    parameter int READ_LATENCY = 2
) (
    input  logic     clk,
    input  logic     rst_n,
    input  arb_tag_t push_tag,
    output logic     vga_rvalid,
    output logic     dec_rvalid
);

    arb_tag_t pipe_q [READ_LATENCY];
    arb_tag_t pipe_d [READ_LATENCY];

    always_comb begin
        pipe_d[0] = push_tag;
        for (int i = 1; i < READ_LATENCY; i++) begin
            pipe_d[i] = pipe_q[i-1];
        end
    end

    // Clearing the line on reset drops every read still in flight.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pipe_q <= '{default: TAG_NONE};
        end else begin
            pipe_q <= pipe_d;
        end
    end

    assign vga_rvalid = (pipe_q[READ_LATENCY-1] == TAG_VGA);
    assign dec_rvalid = (pipe_q[READ_LATENCY-1] == TAG_DEC);

endmodule

// File: rtl/sram_arbiter.sv
// rtl/sram_arbiter.sv - VGA/UART/decoder arbiter for the SRAM port
// Optional build macro SRAM_ARB_STARVE_GUARD_EN adds the decoder starvation guard.
module sram_arbiter
    import sram_arb_pkg::*;
#(
    parameter int READ_LATENCY = 2,
    parameter int STARVE_LIMIT = 16
) (
    input  logic          Clock_50,
    input  logic          Resetn,
    sram_arbiter_if.slave bus
);

    arb_state_t             state_q, state_d;
    logic [SRAM_ADDR_W-1:0] addr_q, addr_d;
    logic [SRAM_DATA_W-1:0] wdata_q, wdata_d;
    logic                   we_n_q, we_n_d;
    logic                   vga_gnt, uart_gnt, dec_gnt;
    logic                   dec_starved;
    arb_tag_t               push_tag;
    logic                   vga_rvalid, dec_rvalid;

`ifdef SRAM_ARB_STARVE_GUARD_EN
    localparam logic [7:0] STARVE_LIMIT_C = 8'(STARVE_LIMIT);

    logic [7:0] starve_q, starve_d;

    always_comb begin
        starve_d = starve_q;
        if (dec_gnt) begin
            starve_d = 8'd0;
        end else if (bus.DEC_req && (starve_q != 8'hFF)) begin
            starve_d = starve_q + 8'd1;
        end
    end

    always_ff @(posedge Clock_50 or negedge Resetn) begin
        if (!Resetn) begin
            starve_q <= 8'd0;
        end else begin
            starve_q <= starve_d;
        end
    end

    // The counter clears on the boosted accept, so the boost lasts one accept.
    assign dec_starved = bus.DEC_req && (starve_q >= STARVE_LIMIT_C);
`else
    assign dec_starved = 1'b0;
`endif

    always_ff @(posedge Clock_50 or negedge Resetn) begin
        if (!Resetn) begin
            state_q <= S_FREE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_FREE: begin
                if (dec_gnt && bus.DEC_lock) begin
                    state_d = S_DEC_LOCKED;
                end
            end
            S_DEC_LOCKED: begin
                if (!bus.DEC_lock || !bus.DEC_req) begin
                    state_d = S_FREE;
                end
            end
            default: state_d = S_FREE;
        endcase
    end

    // UART is simply skipped while locked; VGA keeps its place at the top.
    always_comb begin
        vga_gnt  = 1'b0;
        uart_gnt = 1'b0;
        dec_gnt  = 1'b0;
        if (Resetn) begin
            if (dec_starved) begin
                dec_gnt = 1'b1;
            end else if (bus.VGA_req) begin
                vga_gnt = 1'b1;
            end else if ((state_q == S_FREE) && bus.UART_req) begin
                uart_gnt = 1'b1;
            end else if (bus.DEC_req) begin
                dec_gnt = 1'b1;
            end
        end
    end

    always_comb begin
        addr_d   = addr_q;
        wdata_d  = wdata_q;
        we_n_d   = 1'b1;
        push_tag = TAG_NONE;
        if (vga_gnt) begin
            addr_d   = bus.VGA_addr;
            push_tag = TAG_VGA;
        end else if (uart_gnt) begin
            addr_d  = bus.UART_addr;
            wdata_d = bus.UART_wdata;
            we_n_d  = 1'b0;
        end else if (dec_gnt) begin
            addr_d   = bus.DEC_addr;
            wdata_d  = bus.DEC_wdata;
            we_n_d   = bus.DEC_we_n;
            push_tag = bus.DEC_we_n ? TAG_DEC : TAG_NONE;
        end
    end

    always_ff @(posedge Clock_50 or negedge Resetn) begin
        if (!Resetn) begin
            addr_q  <= '0;
            wdata_q <= '0;
            we_n_q  <= 1'b1;
        end else begin
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            we_n_q  <= we_n_d;
        end
    end

    sram_arb_tag_pipe #(
        .READ_LATENCY (READ_LATENCY)
    ) u_tag_pipe (
        .clk        (Clock_50),
        .rst_n      (Resetn),
        .push_tag   (push_tag),
        .vga_rvalid (vga_rvalid),
        .dec_rvalid (dec_rvalid)
    );

    assign bus.VGA_gnt         = vga_gnt;
    assign bus.UART_gnt        = uart_gnt;
    assign bus.DEC_gnt         = dec_gnt;
    assign bus.VGA_rvalid      = vga_rvalid;
    assign bus.DEC_rvalid      = dec_rvalid;
    assign bus.SRAM_address    = addr_q;
    assign bus.SRAM_write_data = wdata_q;
    assign bus.SRAM_we_n       = we_n_q;
    assign bus.SRAM_rdata      = bus.SRAM_read_data;

    a_one_grant: assert property (@(posedge Clock_50) disable iff (!Resetn)
        $onehot0({vga_gnt, uart_gnt, dec_gnt}));

endmodule

// File: tb/tb_sram_arbiter.sv
// tb/tb_sram_arbiter.sv - self-checking bench for sram_arbiter
`timescale 1ns/1ps
module tb_sram_arbiter;
    import sram_arb_pkg::*;

    localparam int LAT    = 2;
    localparam int STARVE = 16;

    logic clk  = 1'b0;
    logic rstn = 1'b0;
    always #5 clk = ~clk;

    sram_arbiter_if bus ();

    sram_arbiter #(.READ_LATENCY(LAT), .STARVE_LIMIT(STARVE)) dut (
        .Clock_50 (clk),
        .Resetn   (rstn),
        .bus      (bus)
    );

    // SRAM controller emulator: data for the address registered at edge k is valid after edge k+1.
    bit   [15:0] emu_mem [0:262143];
    logic [15:0] emu_rd   = '0;
    logic        pre_en   = 1'b0;
    logic [17:0] pre_addr = '0;
    logic [15:0] pre_data = '0;

    always @(posedge clk) begin
        if (pre_en) emu_mem[pre_addr] <= pre_data;
        else if (!bus.SRAM_we_n) emu_mem[bus.SRAM_address] <= bus.SRAM_write_data;
        emu_rd <= emu_mem[bus.SRAM_address];
    end
    assign bus.SRAM_read_data = emu_rd;

    typedef struct { int tag; logic [15:0] data; } ret_t;   // tag 0 none, 1 VGA, 2 DEC
    typedef struct { logic v, u, d, dwe; logic [2:0] g; logic we; } vec_t;

    ret_t        m_ret[$];
    logic [15:0] m_mem [int];
    bit          m_locked;
    int          m_starve;
    logic [17:0] m_addr;
    logic [15:0] m_wdata;
    logic        m_we_n;

    int total = 0, bad = 0;
    int decg, ublk, first, ndec, seen;
    vec_t tbl [8];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [2:0] gnts();
        return {bus.VGA_gnt, bus.UART_gnt, bus.DEC_gnt};
    endfunction

    function automatic logic [15:0] mem_rd(input logic [17:0] a);
        return m_mem.exists(int'(a)) ? m_mem[int'(a)] : 16'h0;
    endfunction

    function automatic bit wants(input int who);
        case (who)
            1: return bus.VGA_req;
            2: return bus.UART_req;
            3: return bus.DEC_req;
            default: return 1'b0;
        endcase
    endfunction

    // Winner: 0 none, 1 VGA, 2 UART, 3 DEC, taken from an ordered priority list.
    function automatic int m_winner();
        int order[$];
`ifdef SRAM_ARB_STARVE_GUARD_EN
        if (bus.DEC_req && m_starve >= STARVE) return 3;
`endif
        if (m_locked) order = {1, 3};
        else order = {1, 2, 3};
        foreach (order[i]) if (wants(order[i])) return order[i];
        return 0;
    endfunction

    task automatic m_reset();
        ret_t r;
        r.tag = 0; r.data = 16'h0;
        m_locked = 0; m_starve = 0;
        m_addr = '0; m_wdata = '0; m_we_n = 1'b1;
        m_ret.delete();
        repeat (LAT) m_ret.push_back(r);
    endtask

    task automatic m_edge(input int w);
        ret_t r;
        r.tag = 0; r.data = 16'h0;
        m_we_n = 1'b1;
        case (w)
            1: begin
                r.tag = 1; r.data = mem_rd(bus.VGA_addr);
                m_addr = bus.VGA_addr;
            end
            2: begin
                m_addr = bus.UART_addr; m_wdata = bus.UART_wdata; m_we_n = 1'b0;
                m_mem[int'(bus.UART_addr)] = bus.UART_wdata;
            end
            3: begin
                m_addr = bus.DEC_addr; m_wdata = bus.DEC_wdata; m_we_n = bus.DEC_we_n;
                if (bus.DEC_we_n) begin
                    r.tag = 2; r.data = mem_rd(bus.DEC_addr);
                end else begin
                    m_mem[int'(bus.DEC_addr)] = bus.DEC_wdata;
                end
            end
            default: ;
        endcase
        m_ret.push_back(r);
        void'(m_ret.pop_front());
        if (w == 3) m_starve = 0;
        else if (bus.DEC_req && m_starve < 255) m_starve++;
        if (!m_locked) m_locked = (w == 3) && bus.DEC_lock;
        else if (!bus.DEC_lock || !bus.DEC_req) m_locked = 0;
    endtask

    task automatic idle();
        bus.VGA_req = 0;  bus.VGA_addr = '0;
        bus.UART_req = 0; bus.UART_addr = '0; bus.UART_wdata = '0;
        bus.DEC_req = 0;  bus.DEC_we_n = 1;   bus.DEC_addr = '0;
        bus.DEC_wdata = '0; bus.DEC_lock = 0;
    endtask

    // Entered just after a rising edge; compares against the model, then steps one edge.
    task automatic run_cycle();
        int w;
        @(negedge clk);
        w = m_winner();
        check("gnt", {29'd0, gnts()}, {29'd0, w == 1, w == 2, w == 3});
        check("addr", 32'(bus.SRAM_address), 32'(m_addr));
        check("we_n", 32'(bus.SRAM_we_n), 32'(m_we_n));
        if (!m_we_n) check("wdata", 32'(bus.SRAM_write_data), 32'(m_wdata));
        check("rvalid", {30'd0, bus.VGA_rvalid, bus.DEC_rvalid},
              {30'd0, m_ret[0].tag == 1, m_ret[0].tag == 2});
        if (m_ret[0].tag != 0) check("rdata", 32'(bus.SRAM_rdata), 32'(m_ret[0].data));
        @(posedge clk);
        m_edge(w);
        #1;
    endtask

    initial begin
        idle();
        m_reset();
        bus.VGA_req = 1'b1;
        repeat (3) @(posedge clk);
        #3;
        check("rst_gnt", 32'(gnts()), 0);
        check("rst_addr", 32'(bus.SRAM_address), 0);
        check("rst_we_n", 32'(bus.SRAM_we_n), 1);
        check("rst_wdata", 32'(bus.SRAM_write_data), 0);
        check("rst_rvalid", {30'd0, bus.VGA_rvalid, bus.DEC_rvalid}, 0);
        bus.VGA_req = 1'b0;
        @(negedge clk) rstn = 1'b1;
        @(posedge clk); m_edge(m_winner()); #1;

        // Reset while a VGA read is in flight
        bus.VGA_req = 1; bus.VGA_addr = 18'h00010;
        run_cycle();
        bus.VGA_req = 0;
        @(negedge clk) rstn = 1'b0;
        m_reset();
        #1;
        check("rmr_addr", 32'(bus.SRAM_address), 0);
        check("rmr_we_n", 32'(bus.SRAM_we_n), 1);
        seen = 0;
        @(posedge clk); #1 seen |= int'(bus.VGA_rvalid);
        @(negedge clk) rstn = 1'b1;
        repeat (4) begin
            @(posedge clk); m_edge(m_winner()); #1;
            seen |= int'(bus.VGA_rvalid);
        end
        check("rmr_no_rvalid", seen, 0);

        // Free-state priority table: {VGA, UART, DEC, DEC_we_n} -> grants and SRAM_we_n after the edge
        tbl[0] = '{1'b0, 1'b0, 1'b0, 1'b1, 3'b000, 1'b1};
        tbl[1] = '{1'b1, 1'b0, 1'b0, 1'b1, 3'b100, 1'b1};
        tbl[2] = '{1'b0, 1'b1, 1'b0, 1'b1, 3'b010, 1'b0};
        tbl[3] = '{1'b0, 1'b0, 1'b1, 1'b1, 3'b001, 1'b1};
        tbl[4] = '{1'b0, 1'b0, 1'b1, 1'b0, 3'b001, 1'b0};
        tbl[5] = '{1'b1, 1'b1, 1'b1, 1'b0, 3'b100, 1'b1};
        tbl[6] = '{1'b0, 1'b1, 1'b1, 1'b0, 3'b010, 1'b0};
        tbl[7] = '{1'b1, 1'b0, 1'b1, 1'b0, 3'b100, 1'b1};
        for (int i = 0; i < 8; i++) begin
            bus.VGA_req = tbl[i].v; bus.UART_req = tbl[i].u;
            bus.DEC_req = tbl[i].d; bus.DEC_we_n = tbl[i].dwe; bus.DEC_lock = 0;
            bus.VGA_addr = 18'(i + 8); bus.UART_addr = 18'(i + 16); bus.DEC_addr = 18'(i + 24);
            bus.UART_wdata = 16'(i * 3 + 1); bus.DEC_wdata = 16'(i * 5 + 2);
            #2;
            check("tbl_gnt", 32'(gnts()), 32'(tbl[i].g));
            run_cycle();
            check("tbl_we_n", 32'(bus.SRAM_we_n), 32'(tbl[i].we));
        end
        idle();

        // Contention: all three at once, each drops after its grant
        bus.VGA_req = 1;  bus.VGA_addr = 18'h00100;
        bus.UART_req = 1; bus.UART_addr = 18'h00200; bus.UART_wdata = 16'hA5A5;
        bus.DEC_req = 1;  bus.DEC_addr = 18'h00300; bus.DEC_we_n = 1;
        #2 check("cont_g1", 32'(gnts()), 4);
        run_cycle();
        check("cont_a1", 32'(bus.SRAM_address), 32'h100);
        bus.VGA_req = 0;
        #2 check("cont_g2", 32'(gnts()), 2);
        run_cycle();
        check("cont_a2", 32'(bus.SRAM_address), 32'h200);
        bus.UART_req = 0;
        #2 check("cont_g3", 32'(gnts()), 1);
        run_cycle();
        check("cont_a3", 32'(bus.SRAM_address), 32'h300);
        idle();

        // Read latency with a preloaded location
        pre_en = 1; pre_addr = 18'h00020; pre_data = 16'hBEEF;
        m_mem[32'h20] = 16'hBEEF;
        run_cycle();
        pre_en = 0;
        bus.DEC_req = 1; bus.DEC_we_n = 1; bus.DEC_addr = 18'h00020;
        run_cycle();
        idle();
        check("lat_early", 32'(bus.DEC_rvalid), 0);
        run_cycle();
        check("lat_rvalid", 32'(bus.DEC_rvalid), 1);
        check("lat_data", 32'(bus.SRAM_rdata), 32'hBEEF);
        run_cycle();
        check("lat_late", 32'(bus.DEC_rvalid), 0);

        // Lock: decoder burst of 8 reads against UART, VGA cuts in once
        decg = 0; ublk = 0;
        bus.DEC_req = 1; bus.DEC_we_n = 1; bus.DEC_lock = 1;
        for (int i = 0; i < 9; i++) begin
            bus.UART_req = (i > 0); bus.UART_addr = 18'h00500; bus.UART_wdata = 16'h5555;
            bus.VGA_req = (i == 4); bus.VGA_addr = 18'h00600;
            bus.DEC_addr = 18'h00040 + 18'(decg);
            #2;
            ublk |= int'(bus.UART_gnt);
            if (bus.DEC_gnt) decg++;
            if (i == 4) check("lock_vga_preempt", 32'(gnts()), 4);
            if (i == 5) check("lock_dec_resume", 32'(gnts()), 1);
            run_cycle();
        end
        check("lock_dec_count", decg, 8);
        bus.DEC_req = 0; bus.DEC_lock = 0; bus.VGA_req = 0;
        #2 ublk |= int'(bus.UART_gnt);
        check("lock_uart_blocked", ublk, 0);
        run_cycle();
        #2 check("lock_uart_after", 32'(gnts()), 2);
        run_cycle();
        idle();

        // UART write to the top address, decoder reads it back
        bus.UART_req = 1; bus.UART_addr = 18'h3FFFF; bus.UART_wdata = 16'h1234;
        run_cycle();
        check("uw_we_n", 32'(bus.SRAM_we_n), 0);
        check("uw_addr", 32'(bus.SRAM_address), 32'h3FFFF);
        check("uw_wdata", 32'(bus.SRAM_write_data), 32'h1234);
        idle();
        bus.DEC_req = 1; bus.DEC_we_n = 1; bus.DEC_addr = 18'h3FFFF;
        run_cycle();
        check("uw_we_n_once", 32'(bus.SRAM_we_n), 1);
        idle();
        run_cycle();
        check("uw_rvalid", 32'(bus.DEC_rvalid), 1);
        check("uw_rdata", 32'(bus.SRAM_rdata), 32'h1234);

        // Starvation: VGA and decoder both held
        bus.VGA_req = 1; bus.VGA_addr = 18'h00700;
        bus.DEC_req = 1; bus.DEC_addr = 18'h00710; bus.DEC_we_n = 1;
        first = 0; ndec = 0;
        for (int c = 1; c <= 33; c++) begin
            #2;
            if (bus.DEC_gnt) begin
                ndec++;
                if (first == 0) first = c;
            end
            run_cycle();
        end
`ifdef SRAM_ARB_STARVE_GUARD_EN
        check("starve_first", first, STARVE + 1);
        check("starve_once", ndec, 1);
`else
        check("starve_never", ndec, 0);
`endif
        idle();

        // Randomised traffic against the model
        for (int n = 0; n < 400; n++) begin
            bus.VGA_req    = ($urandom_range(0, 3) == 0);
            bus.UART_req   = ($urandom_range(0, 4) < 2);
            bus.DEC_req    = ($urandom_range(0, 4) < 3);
            bus.DEC_we_n   = $urandom_range(0, 1) == 1;
            bus.DEC_lock   = ($urandom_range(0, 9) < 7);
            bus.VGA_addr   = 18'($urandom_range(0, 7));
            bus.UART_addr  = 18'($urandom_range(0, 7));
            bus.DEC_addr   = 18'($urandom_range(0, 7));
            bus.UART_wdata = 16'($urandom);
            bus.DEC_wdata  = 16'($urandom);
            run_cycle();
        end
        idle();
        repeat (LAT + 1) run_cycle();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/sram_arbiter.md
Name: sram_arbiter

Overview:
- Shares the single external SRAM port between three requesters: VGA fetch (read-only, real-time), UART loader (write-only) and the decoder (read/write).
- Sits between the requesters and the SRAM controller.
- Registers the winning address, write data and write enable each cycle.
- Routes read data back to the requester that issued the read, through a tag pipeline matched to the SRAM read latency.

Parameters:
READ_LATENCY, 2, cycles from the accept edge to valid SRAM_read_data; legal range 1-4
STARVE_LIMIT, 16, consecutive blocked decoder cycles before the guard fires (SRAM_ARB_STARVE_GUARD_EN only)

Ports:
Clock_50  in  1  system clock
Resetn  in  1  asynchronous active-low reset
VGA_req  in  1  VGA read request
VGA_addr  in  18  VGA read address
VGA_gnt  out  1  VGA request accepted this cycle
VGA_rvalid  out  1  SRAM_rdata belongs to VGA
UART_req  in  1  UART write request
UART_addr  in  18  UART write address
UART_wdata  in  16  UART write data
UART_gnt  out  1  UART request accepted
DEC_req  in  1  decoder request
DEC_we_n  in  1  decoder write enable, active-low
DEC_addr  in  18  decoder address
DEC_wdata  in  16  decoder write data
DEC_lock  in  1  decoder holds the grant against UART
DEC_gnt  out  1  decoder request accepted
DEC_rvalid  out  1  SRAM_rdata belongs to the decoder
SRAM_address  out  18  registered address to the SRAM controller
SRAM_write_data  out  16  registered write data
SRAM_we_n  out  1  registered write enable, active-low
SRAM_read_data  in  16  data from the SRAM controller
SRAM_rdata  out  16  SRAM_read_data passed through to all readers

Behaviour:
- Reset (async, Resetn=0):
  - SRAM_address=0, SRAM_write_data=0, SRAM_we_n=1.
  - All gnt=0 and all rvalid=0; tag pipeline cleared.
  - State S_FREE; starvation counter 0.
  - Reads in flight are dropped and no rvalid is issued for them.
- Grant timing:
  - gnt is combinational from the current req/state.
  - A request is accepted when req&gnt is high at an edge.
  - At most one gnt is high per cycle.
- Output registers: on the accept edge, SRAM_address, SRAM_write_data and SRAM_we_n load from the winner. SRAM_we_n=0 for UART, DEC_we_n for the decoder, 1 for VGA.
- No accept: SRAM_we_n=1; address and write data hold their values.
- Read return:
  - A read accepted at edge k pushes a tag (VGA/DEC) into a READ_LATENCY-deep shift register.
  - That requester's rvalid is high in the cycle after edge k+READ_LATENCY-1, coincident with valid SRAM_read_data.
  - Writes push tag NONE.
- Priority in S_FREE: VGA > UART > DEC.
- State machine:
  - S_FREE -> S_DEC_LOCKED: on a decoder accept with DEC_lock=1.
  - S_DEC_LOCKED: priority VGA > DEC; UART is blocked. VGA always preempts (its real-time deadline is never blocked).
  - S_DEC_LOCKED -> S_FREE: on any edge where DEC_lock=0 or DEC_req=0.
- Simultaneous events: a VGA accept during S_DEC_LOCKED keeps the state at S_DEC_LOCKED.
- Back-to-back: one accept per cycle is sustained indefinitely. A read followed by a write on the next cycle is legal; the controller handles turnaround.
- Addresses pass through unmodified, with no wrap logic.

Optional Feature:
- SRAM_ARB_STARVE_GUARD_EN defined:
  - An 8-bit counter increments each cycle DEC_req=1 && DEC_gnt=0, and clears on a decoder accept.
  - When the counter reaches STARVE_LIMIT, the decoder has top priority (above VGA) for exactly one accept.
  - The counter saturates; it does not wrap.
- Undefined: strict priority as above; no counter logic is present.

Decomposition:
- Package sram_arb_pkg holds:
  - enum arb_state_t {S_FREE, S_DEC_LOCKED}
  - enum arb_tag_t {TAG_NONE, TAG_VGA, TAG_DEC}
  - localparam SRAM_ADDR_W=18, SRAM_DATA_W=16
- One sub-module, sram_arb_tag_pipe: parameterised READ_LATENCY shift register of arb_tag_t, producing the per-requester rvalid outputs.

Test Plan:
- Reset mid-read:
  - Stimulus: VGA read of 0x00010 accepted, then Resetn pulsed low one cycle later.
  - Required: VGA_rvalid never asserts; SRAM_we_n=1; SRAM_address=0.
- Contention:
  - Stimulus: VGA, UART and DEC all request in the same cycle.
  - Required: grant order VGA, UART, DEC on three consecutive edges; SRAM_address sequence matches.
- Read latency:
  - Stimulus: emulator preloaded with 0x00020=0xBEEF; decoder reads 0x00020 with READ_LATENCY=2.
  - Required: DEC_rvalid=1 with SRAM_rdata=0xBEEF exactly 2 cycles after the accept edge.
- Lock:
  - Stimulus: DEC_lock=1 with 8 decoder reads while UART_req=1 throughout, plus one VGA request mid-burst.
  - Required: UART_gnt stays 0 until DEC_lock drops; VGA preempts once; the decoder resumes.
- UART writes:
  - Stimulus: UART writes 0x1234 to 0x3FFFF, then the decoder reads 0x3FFFF.
  - Required: SRAM_we_n=0 for one cycle with address 0x3FFFF; DEC_rdata=0x1234.
- Starvation guard (macro on, STARVE_LIMIT=16):
  - Stimulus: VGA_req held at 1, DEC_req held at 1.
  - Required: DEC_gnt=1 on the 17th cycle, exactly once; with the macro off, DEC_gnt never asserts.
